// File: rtl/processor_arbiter_if.sv
// processor_arbiter_if
//   Operand/result bundle between the arbiter and the shared processor
//   datapath.
//   master (arbiter side) : drives p_data_in, p_i_data, p_data_select,
//                           p_status_flags; receives p_data_out, p_status
//   slave  (processor side): the mirror image of master
interface processor_arbiter_if;
    logic [31:0] p_data_in;
    logic [31:0] p_i_data;
    logic        p_data_select;
    logic [15:0] p_status_flags;
    logic [31:0] p_data_out;
    logic [7:0]  p_status;

    modport master (
        output p_data_in,
        output p_i_data,
        output p_data_select,
        output p_status_flags,
        input  p_data_out,
        input  p_status
    );

    modport slave (
        input  p_data_in,
        input  p_i_data,
        input  p_data_select,
        input  p_status_flags,
        output p_data_out,
        output p_status
    );
endinterface

// File: rtl/processor_arbiter.sv
// processor_arbiter
//   Round-robin arbiter/sequencer sharing one processor datapath among N
//   requesters. One operation in flight at a time: grant, present operands,
//   wait LATENCY cycles, capture result, pulse done to the owner.
//   Ports:
//     clk, rstN            clock, asynchronous active-low reset
//     req                  per-requester request level
//     req_data_in/i_data   packed 32-bit operands, requester k at [32k+:32]
//     req_data_select      select bit per requester
//     req_status_flags     packed 16-bit flags, requester k at [16k+:16]
//     gnt                  one-hot pulse: operands of that requester captured
//     done                 one-hot pulse: rsp_* valid for that requester
//     rsp_data/rsp_status  captured processor result
//     rsp_err              captured status[6:5] != 2'b11
//     owner                index of the current/last granted requester
//     busy                 high whenever the sequencer is not idle
//     proc_bus             operand/result bundle to the processor
module processor_arbiter #(
    parameter int  N       = 4,
    parameter int  LATENCY = 1,
    localparam int IW      = $clog2(N)
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic [N-1:0]        req,
    input  logic [32*N-1:0]     req_data_in,
    input  logic [32*N-1:0]     req_i_data,
    input  logic [N-1:0]        req_data_select,
    input  logic [16*N-1:0]     req_status_flags,
    output logic [N-1:0]        gnt,
    output logic [N-1:0]        done,
    output logic [31:0]         rsp_data,
    output logic [7:0]          rsp_status,
    output logic                rsp_err,
    output logic [IW-1:0]       owner,
    output logic                busy,
    processor_arbiter_if.master proc_bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int CW = 4;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [N-1:0]  done_q, done_d;
    logic [31:0]   pdi_q, pdi_d;
    logic [31:0]   pid_q, pid_d;
    logic          psel_q, psel_d;
    logic [15:0]   pfl_q, pfl_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic [7:0]    rsp_status_q, rsp_status_d;
    logic          rsp_err_q, rsp_err_d;

    // Unpacked views of the packed per-requester operand buses.
    logic [31:0] a_arr [N];
    logic [31:0] b_arr [N];
    logic [15:0] f_arr [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign a_arr[gi] = req_data_in[32*gi +: 32];
        assign b_arr[gi] = req_i_data[32*gi +: 32];
        assign f_arr[gi] = req_status_flags[16*gi +: 16];
    end

    // Round-robin pick: scan from ptr upward with wrap. Iterating from the
    // far end downward lets the closest set bit win by overwriting last.
    logic          win_valid;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr_q) + k) % N);
            if (req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        gnt_d        = '0;
        done_d       = '0;
        pdi_d        = pdi_q;
        pid_d        = pid_q;
        psel_d       = psel_q;
        pfl_d        = pfl_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    pdi_d          = a_arr[win_idx];
                    pid_d          = b_arr[win_idx];
                    psel_d         = req_data_select[win_idx];
                    pfl_d          = f_arr[win_idx];
                    owner_d        = win_idx;
                    gnt_d[win_idx] = 1'b1;
                    ptr_d          = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CW'(LATENCY - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d   = proc_bus.p_data_out;
                    rsp_status_d = proc_bus.p_status;
                    rsp_err_d    = (proc_bus.p_status[6:5] != 2'b11);
                    state_d      = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                // done is registered, so it appears in the cycle after DONE,
                // which is also the first IDLE cycle; a grant made there
                // shows up one cycle later, so gnt and done never overlap.
                done_d[owner_q] = 1'b1;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ptr_q        <= '0;
            owner_q      <= '0;
            gnt_q        <= '0;
            done_q       <= '0;
            pdi_q        <= '0;
            pid_q        <= '0;
            psel_q       <= 1'b0;
            pfl_q        <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            pdi_q        <= pdi_d;
            pid_q        <= pid_d;
            psel_q       <= psel_d;
            pfl_q        <= pfl_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;
    assign rsp_err    = rsp_err_q;
    assign owner      = owner_q;
    assign busy       = (state_q != S_IDLE);

    assign proc_bus.p_data_in      = pdi_q;
    assign proc_bus.p_i_data       = pid_q;
    assign proc_bus.p_data_select  = psel_q;
    assign proc_bus.p_status_flags = pfl_q;

endmodule

// File: doc/processor_arbiter.md
# processor_arbiter

Round-robin arbiter and sequencer that shares one `processor` datapath among N requesters. It accepts one operation at a time (data_in, i_data, data_select, status_flags) and drives the operands onto the processor. After a fixed processor latency it captures data_out and status and returns them to the granted requester with a one-cycle done pulse. It sits between the requester blocks and the `processor` instance, and is the only driver of the processor's operand inputs.

## Interface
- N, 4, number of requesters (2..8); IW = $clog2(N)
- LATENCY, 1, processor cycles from operand sample edge to valid data_out/status (1..15)
- clk  input  1  system clock, all logic on rising edge
- rstN  input  1  asynchronous active-low reset
- req  input  N  per-requester request level
- req_data_in  input  32*N  operand A, requester k in bits [32k+31:32k]
- req_i_data  input  32*N  operand B, same packing
- req_data_select  input  N  select bit per requester
- req_status_flags  input  16*N  flags per requester, [16k+15:16k]
- gnt  output  N  one-hot, one-cycle pulse: operands captured
- done  output  N  one-hot, one-cycle pulse: rsp_* valid for that requester
- rsp_data  output  32  captured processor data_out
- rsp_status  output  8  captured processor status
- rsp_err  output  1  valid with done: captured status[6:5] != 2'b11
- owner  output  IW  index of current/last granted requester
- busy  output  1  high in every state except IDLE
- p_data_in, p_i_data  output  32  to processor
- p_data_select  output  1  to processor
- p_status_flags  output  16  to processor
- p_data_out  input  32  from processor
- p_status  input  8  from processor

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE; reset state IDLE.
- IDLE: if any req bit is set, choose winner w as the first set bit searching from pointer ptr upward with wrap (ptr, ptr+1, ..., N-1, 0, ...). At that edge, register w's operands into p_*, set owner=w, pulse gnt[w], set ptr=(w+1) mod N, and go to ISSUE. If no req is set, stay in IDLE and hold all outputs.
- ISSUE: p_* are stable for the whole cycle. Load cnt=LATENCY-1 and go to WAIT.
- WAIT: if cnt==0, capture p_data_out into rsp_data and p_status into rsp_status, compute rsp_err, and go to DONE. Otherwise decrement cnt.
- DONE: done[owner]=1 for this cycle only, then go to IDLE.
- p_* hold their last operands until the next grant. rsp_* hold until the next capture.
- A requester must hold req and its operands stable until it sees gnt. It deasserts req the cycle after gnt. A req still high in IDLE after DONE is treated as a new operation.
- req changes outside IDLE are ignored (not latched). Pending requests are arbitrated at the next IDLE.
- Dropping req before gnt is legal; that requester is simply not granted.
- Requester index N-1 wraps ptr to 0.
- Reset values: gnt=0, done=0, rsp_data=0, rsp_status=0, rsp_err=0, owner=0, busy=0, ptr=0, cnt=0, all p_*=0.
- Reset asserted mid-operation: immediate return to IDLE with the reset values above. No done pulse is issued for the aborted operation.

## Timing
- Grant edge t0: the edge in IDLE where req is sampled. gnt[w] and p_* are valid in cycle t0..t0+1.
- The processor samples operands at t0+1.
- Capture edge is t0+1+LATENCY. done is high in cycle t0+2+LATENCY..t0+3+LATENCY.
- Next grant is at the earliest t0+3+LATENCY, so one operation completes per LATENCY+3 cycles.
- gnt and done are never both high in the same cycle.
- At most one gnt bit and at most one done bit are ever set.

## Test plan
- Single op, LATENCY=1: req[2]=1 with data_in=5, i_data=7, sel=1, flags=16'h00FF, processor returning status=8'hFF. Required: gnt[2] pulses at t0; p_data_in=5 during ISSUE; done[2] at t0+3 with rsp_status=8'hFF, rsp_err=0, owner=2.
- Full contention: req=4'b1111 held continuously. Required: grant order 0,1,2,3,0 with grants every 4 cycles (LATENCY=1).
- Wrap: ptr=3 after grant to 2, then req=4'b1001. Required: grant to 3, then 0.
- Status error: processor status=8'b0110_0000 masked to 8'b0000_0000 at capture. Required: rsp_err=1 with the done pulse; with status=8'b0110_0000 itself, rsp_err=0.
- Reset mid-WAIT with LATENCY=4: rstN=0 two cycles after the grant. Required: all outputs 0 immediately; no done; after release, req=4'b0010 is granted to requester 1 (ptr was reset to 0).
- Early withdraw: req[1] pulses for one cycle while busy. Required: never granted; no gnt[1] and no done[1].
